// File: rtl/counter_chain_acc.sv
// Chained weighted column counters: compresses N_STAGES groups of bit columns into one
// exact binary sum per sample, then keeps a streaming running total of those sums.
module counter_chain_acc #(
  parameter int    N_STAGES = 2,
  parameter string OUTREG   = "FALSE",
  parameter string USETNM   = "USET0",
  parameter int    ACC_W    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_in_valid,
  input  logic [2*N_STAGES:0]   i_c0,
  input  logic [2*N_STAGES-1:0] i_c1,
  input  logic [2*N_STAGES-1:0] i_c2,
  input  logic                  i_acc_clr,
  output logic [2*N_STAGES+2:0] o_sum,
  output logic                  o_sum_valid,
  output logic [ACC_W-1:0]      o_acc,
  output logic                  o_acc_valid,
  output logic                  o_acc_ovf
);
  localparam int SW  = 2*N_STAGES + 3;
  localparam int AW1 = ACC_W + 1;

  // Placement group name only; it carries no logic.
  if (USETNM == "") begin : g_no_group
  end

  function automatic logic [1:0] popcnt2(input logic [1:0] b);
    popcnt2 = {1'b0, b[0]} + {1'b0, b[1]};
  endfunction

  function automatic logic [1:0] popcnt3(input logic [2:0] b);
    popcnt3 = {1'b0, b[0]} + {1'b0, b[1]} + {1'b0, b[2]};
  endfunction

  logic [2*N_STAGES:0]   r_c0;
  logic [2*N_STAGES-1:0] r_c1;
  logic [2*N_STAGES-1:0] r_c2;
  logic                  r_in_valid;
  logic                  r_in_clr;

  // Input register: samples columns and tags every cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_c0       <= '0;
      r_c1       <= '0;
      r_c2       <= '0;
      r_in_valid <= 1'b0;
      r_in_clr   <= 1'b0;
    end else begin
      r_c0       <= i_c0;
      r_c1       <= i_c1;
      r_c2       <= i_c2;
      r_in_valid <= i_in_valid;
      r_in_clr   <= i_acc_clr;
    end
  end

  // Each stage keeps two result bits and ripples bits [4:2] up as a carry of up to 4,
  // so the partials never exceed 18 and the chain stays exact.
  logic [4:0]    w_part [N_STAGES];
  logic [SW-1:0] w_sum;

  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    logic [1:0] w_n0;
    logic [2:0] w_cin;
    if (k == 0) begin : g_first
      assign w_n0  = popcnt3(r_c0[2:0]);
      assign w_cin = 3'd0;
    end else begin : g_chain
      assign w_n0  = popcnt2(r_c0[2*k+2:2*k+1]);
      assign w_cin = w_part[k-1][4:2];
    end
    assign w_part[k] = {3'b000, w_n0}
                     + {2'b00, popcnt2(r_c1[2*k+1:2*k]), 1'b0}
                     + {1'b0, popcnt2(r_c2[2*k+1:2*k]), 2'b00}
                     + {2'b00, w_cin};
    if (k < N_STAGES-1) begin : g_low
      assign w_sum[2*k+1:2*k] = w_part[k][1:0];
    end else begin : g_top
      assign w_sum[SW-1:2*k] = w_part[k];
    end
  end

  logic [SW-1:0] w_st_sum;
  logic          w_st_valid;
  logic          w_st_clr;

  if (OUTREG == "TRUE") begin : g_outreg
    logic [SW-1:0] r_mid_sum;
    logic          r_mid_valid;
    logic          r_mid_clr;

    // Optional retiming register between compressor and sum register.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_mid_sum   <= '0;
        r_mid_valid <= 1'b0;
        r_mid_clr   <= 1'b0;
      end else begin
        r_mid_sum   <= w_sum;
        r_mid_valid <= r_in_valid;
        r_mid_clr   <= r_in_clr;
      end
    end
    assign w_st_sum   = r_mid_sum;
    assign w_st_valid = r_mid_valid;
    assign w_st_clr   = r_mid_clr;
  end else begin : g_no_outreg
    assign w_st_sum   = w_sum;
    assign w_st_valid = r_in_valid;
    assign w_st_clr   = r_in_clr;
  end

  logic [SW-1:0]    r_sum;
  logic             r_sum_valid;
  logic             r_sum_clr;
  logic [ACC_W-1:0] r_acc;
  logic             r_acc_valid;
  logic             r_acc_ovf;
  logic [ACC_W:0]   w_acc_add;

  // Sum register: holds the last valid sum across bubbles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sum       <= '0;
      r_sum_valid <= 1'b0;
      r_sum_clr   <= 1'b0;
    end else begin
      if (w_st_valid) begin
        r_sum <= w_st_sum;
      end else begin
        r_sum <= r_sum;
      end
      r_sum_valid <= w_st_valid;
      r_sum_clr   <= w_st_clr;
    end
  end

  assign w_acc_add = AW1'(r_acc) + AW1'(r_sum);

  // Accumulator: a clr tag restarts the total; a bubble clear zeroes it silently.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc       <= '0;
      r_acc_valid <= 1'b0;
      r_acc_ovf   <= 1'b0;
    end else begin
      r_acc_valid <= r_sum_valid;
      if (r_sum_valid && r_sum_clr) begin
        r_acc     <= ACC_W'(r_sum);
        r_acc_ovf <= 1'b0;
      end else if (r_sum_valid) begin
        r_acc     <= w_acc_add[ACC_W-1:0];
        r_acc_ovf <= r_acc_ovf | w_acc_add[ACC_W];
      end else if (r_sum_clr) begin
        r_acc     <= '0;
        r_acc_ovf <= 1'b0;
      end else begin
        r_acc     <= r_acc;
        r_acc_ovf <= r_acc_ovf;
      end
    end
  end

  assign o_sum       = r_sum;
  assign o_sum_valid = r_sum_valid;
  assign o_acc       = r_acc;
  assign o_acc_valid = r_acc_valid;
  assign o_acc_ovf   = r_acc_ovf;
endmodule

// File: tb/tb_counter_chain_acc.sv
// Bench for counter_chain_acc: four instances (latency 2 and 3, 8-bit wrapping total,
// four-stage chain) checked against a cycle-stamped scoreboard plus directed sequences.
module tb_counter_chain_acc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst = 1'b1;
  logic       a_v = 1'b0, a_clr = 1'b0;
  logic [4:0] a_c0 = 5'd0;
  logic [3:0] a_c1 = 4'd0, a_c2 = 4'd0;
  logic       d_v = 1'b0, d_clr = 1'b0;
  logic [8:0] d_c0 = 9'd0;
  logic [7:0] d_c1 = 8'd0, d_c2 = 8'd0;

  logic [6:0]  sum_a, sum_b, sum_c;
  logic [10:0] sum_d;
  logic [15:0] acc_a, acc_b, acc_d;
  logic [7:0]  acc_c;
  logic sv_a, sv_b, sv_c, sv_d, av_a, av_b, av_c, av_d, ovf_a, ovf_b, ovf_c, ovf_d;

  counter_chain_acc #(.N_STAGES(2), .OUTREG("FALSE"), .USETNM("USET0"), .ACC_W(16)) u_a (
    .i_clk(clk), .i_rst(rst), .i_in_valid(a_v), .i_c0(a_c0), .i_c1(a_c1), .i_c2(a_c2),
    .i_acc_clr(a_clr), .o_sum(sum_a), .o_sum_valid(sv_a), .o_acc(acc_a),
    .o_acc_valid(av_a), .o_acc_ovf(ovf_a));
  counter_chain_acc #(.N_STAGES(2), .OUTREG("TRUE"), .USETNM("USET0"), .ACC_W(16)) u_b (
    .i_clk(clk), .i_rst(rst), .i_in_valid(a_v), .i_c0(a_c0), .i_c1(a_c1), .i_c2(a_c2),
    .i_acc_clr(a_clr), .o_sum(sum_b), .o_sum_valid(sv_b), .o_acc(acc_b),
    .o_acc_valid(av_b), .o_acc_ovf(ovf_b));
  counter_chain_acc #(.N_STAGES(2), .OUTREG("FALSE"), .USETNM("USET0"), .ACC_W(8)) u_c (
    .i_clk(clk), .i_rst(rst), .i_in_valid(a_v), .i_c0(a_c0), .i_c1(a_c1), .i_c2(a_c2),
    .i_acc_clr(a_clr), .o_sum(sum_c), .o_sum_valid(sv_c), .o_acc(acc_c),
    .o_acc_valid(av_c), .o_acc_ovf(ovf_c));
  counter_chain_acc #(.N_STAGES(4), .OUTREG("FALSE"), .USETNM("USET0"), .ACC_W(16)) u_d (
    .i_clk(clk), .i_rst(rst), .i_in_valid(d_v), .i_c0(d_c0), .i_c1(d_c1), .i_c2(d_c2),
    .i_acc_clr(d_clr), .o_sum(sum_d), .o_sum_valid(sv_d), .o_acc(acc_d),
    .o_acc_valid(av_d), .o_acc_ovf(ovf_d));

  typedef struct { int cyc; logic [15:0] val; logic ovf; } exp_t;
  typedef struct { logic [4:0] c0; logic [3:0] c1; logic [3:0] c2; bit clr; int exp; } vec_t;

  exp_t   sq [4][$];
  exp_t   aq [4][$];
  int     lat [4] = '{2, 3, 2, 2};
  int     aw  [4] = '{16, 16, 8, 16};
  longint macc [4] = '{0, 0, 0, 0};
  bit     movf [4] = '{0, 0, 0, 0};
  int     errors = 0, checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  function automatic int ref_sum(input int n, input logic [16:0] c0, input logic [15:0] c1,
                                 input logic [15:0] c2);
    int s = $countones(c0[2:0]) + 2*$countones(c1[1:0]) + 4*$countones(c2[1:0]);
    for (int k = 1; k < n; k++)
      s += (1 << (2*k)) * ($countones(c0[2*k+1 +: 2]) + 2*$countones(c1[2*k +: 2])
                          + 4*$countones(c2[2*k +: 2]));
    return s;
  endfunction

  // Expected results are stamped with the cycle on which they must appear.
  task automatic push(input int d, input int s, input bit v, input bit clr);
    exp_t   e;
    longint m;
    longint modv = 64'd1 << aw[d];
    if (v) begin
      e.cyc = cyc + lat[d]; e.val = 16'(s); e.ovf = 1'b0;
      sq[d].push_back(e);
      if (clr) begin
        macc[d] = s; movf[d] = 1'b0;
      end else begin
        m = macc[d] + s;
        if (m >= modv) begin m -= modv; movf[d] = 1'b1; end
        macc[d] = m;
      end
      e.cyc = cyc + lat[d] + 1; e.val = 16'(macc[d]); e.ovf = movf[d];
      aq[d].push_back(e);
    end else if (clr) begin
      macc[d] = 0; movf[d] = 1'b0;
    end
  endtask

  task automatic mon(input int d, input logic sv, input logic [15:0] s, input logic av,
                     input logic [15:0] a, input logic ovf);
    exp_t e;
    while (sq[d].size() > 0 && sq[d][0].cyc < cyc) begin
      e = sq[d].pop_front();
      flag($sformatf("sum_missing[%0d] due %0d", d, e.cyc));
    end
    while (aq[d].size() > 0 && aq[d][0].cyc < cyc) begin
      e = aq[d].pop_front();
      flag($sformatf("acc_missing[%0d] due %0d", d, e.cyc));
    end
    if (sv === 1'b1) begin
      if (sq[d].size() == 0 || sq[d][0].cyc != cyc) flag($sformatf("sum_unexpected[%0d]", d));
      else begin
        e = sq[d].pop_front();
        check($sformatf("sum[%0d]", d), {48'd0, s}, {48'd0, e.val});
      end
    end
    if (av === 1'b1) begin
      if (aq[d].size() == 0 || aq[d][0].cyc != cyc) flag($sformatf("acc_unexpected[%0d]", d));
      else begin
        e = aq[d].pop_front();
        check($sformatf("acc[%0d]", d), {48'd0, a}, {48'd0, e.val});
        check($sformatf("acc_ovf[%0d]", d), {63'd0, ovf}, {63'd0, e.ovf});
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, sv_a, {9'd0, sum_a}, av_a, acc_a, ovf_a);
    mon(1, sv_b, {9'd0, sum_b}, av_b, acc_b, ovf_b);
    mon(2, sv_c, {9'd0, sum_c}, av_c, {8'd0, acc_c}, ovf_c);
    mon(3, sv_d, {5'd0, sum_d}, av_d, acc_d, ovf_d);
  end

  task automatic drive_a(input logic [4:0] c0, input logic [3:0] c1, input logic [3:0] c2,
                         input bit v, input bit clr, input int exp_s);
    @(posedge clk); #1;
    a_c0 = c0; a_c1 = c1; a_c2 = c2; a_v = v; a_clr = clr;
    for (int d = 0; d < 3; d++) push(d, exp_s, v, clr);
  endtask

  task automatic drive_d(input logic [8:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                         input bit v, input bit clr);
    @(posedge clk); #1;
    d_c0 = c0; d_c1 = c1; d_c2 = c2; d_v = v; d_clr = clr;
    push(3, ref_sum(4, {8'd0, c0}, {8'd0, c1}, {8'd0, c2}), v, clr);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      a_v = 1'b0; a_clr = 1'b0; d_v = 1'b0; d_clr = 1'b0;
    end
  endtask

  // One reset cycle with a valid sample on the inputs; everything in flight is dropped.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; a_v = 1'b1; a_clr = 1'b0; a_c0 = 5'h1F; a_c1 = 4'hF; a_c2 = 4'hF;
    d_v = 1'b1; d_clr = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; a_v = 1'b0; a_clr = 1'b0; d_v = 1'b0; d_clr = 1'b0;
    for (int d = 0; d < 4; d++) begin
      sq[d].delete(); aq[d].delete(); macc[d] = 0; movf[d] = 1'b0;
    end
    @(negedge clk);
    check("rst_a", {34'd0, sum_a, sv_a, acc_a, av_a, ovf_a}, 64'd0);
    check("rst_b", {34'd0, sum_b, sv_b, acc_b, av_b, ovf_b}, 64'd0);
    check("rst_c", {42'd0, sum_c, sv_c, acc_c, av_c, ovf_c}, 64'd0);
    check("rst_d", {34'd0, sum_d, sv_d, acc_d, av_d, ovf_d}, 64'd0);
  endtask

  task automatic rand_a(input int n);
    logic [4:0] c0;
    logic [3:0] c1, c2;
    bit v, clr;
    for (int i = 0; i < n; i++) begin
      c0 = 5'($urandom); c1 = 4'($urandom); c2 = 4'($urandom);
      v = ($urandom_range(0, 3) != 0); clr = ($urandom_range(0, 15) == 0);
      drive_a(c0, c1, c2, v, clr, ref_sum(2, {12'd0, c0}, {12'd0, c1}, {12'd0, c2}));
    end
  endtask

  vec_t vt [11];
  int   pulses;

  initial begin
    vt[0]  = '{5'b00001, 4'b0000, 4'b0000, 1'b1, 1};
    vt[1]  = '{5'b00000, 4'b0000, 4'b0100, 1'b0, 16};
    vt[2]  = '{5'b01000, 4'b0000, 4'b0000, 1'b0, 4};
    vt[3]  = '{5'b11111, 4'b1111, 4'b1111, 1'b0, 71};
    vt[4]  = '{5'b00000, 4'b0001, 4'b0000, 1'b0, 2};
    vt[5]  = '{5'b00110, 4'b0000, 4'b0000, 1'b0, 2};
    vt[6]  = '{5'b00000, 4'b1000, 4'b0000, 1'b0, 8};
    vt[7]  = '{5'b00000, 4'b0000, 4'b0011, 1'b0, 8};
    vt[8]  = '{5'b10000, 4'b1100, 4'b0000, 1'b0, 20};
    vt[9]  = '{5'b00111, 4'b0011, 4'b0011, 1'b0, 15};
    vt[10] = '{5'b11000, 4'b1100, 4'b1100, 1'b0, 56};

    repeat (2) @(posedge clk);
    do_reset();
    rand_a(20);
    do_reset();

    for (int i = 0; i < 11; i++) drive_a(vt[i].c0, vt[i].c1, vt[i].c2, 1'b1, vt[i].clr, vt[i].exp);
    idle(6);

    drive_a(5'h1F, 4'hF, 4'hF, 1'b1, 1'b1, 71);
    drive_a(5'h1F, 4'hF, 4'hF, 1'b1, 1'b0, 71);
    drive_a(5'h1F, 4'hF, 4'hF, 1'b1, 1'b0, 71);
    idle(6);
    check("acc3_a", {48'd0, acc_a}, 64'd213);
    check("acc3_c", {56'd0, acc_c}, 64'd213);
    check("acc3_ovf_c", {63'd0, ovf_c}, 64'd0);
    drive_a(5'h1F, 4'hF, 4'hF, 1'b1, 1'b0, 71);
    idle(6);
    check("wrap_c", {56'd0, acc_c}, 64'd28);
    check("wrap_ovf_c", {63'd0, ovf_c}, 64'd1);
    check("nowrap_a", {48'd0, acc_a}, 64'd284);
    drive_a(5'h1F, 4'hF, 4'hF, 1'b1, 1'b0, 71);
    idle(6);
    check("sticky_c", {56'd0, acc_c}, 64'd99);
    check("sticky_ovf_c", {63'd0, ovf_c}, 64'd1);

    drive_a(5'h00, 4'h0, 4'h0, 1'b0, 1'b1, 0);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (av_c === 1'b1) pulses++;
    end
    check("bubble_no_valid", 64'(pulses), 64'd0);
    check("bubble_acc_c", {56'd0, acc_c}, 64'd0);
    check("bubble_ovf_c", {63'd0, ovf_c}, 64'd0);
    check("bubble_acc_b", {48'd0, acc_b}, 64'd0);
    check("sum_hold_a", {57'd0, sum_a}, 64'd71);

    rand_a(200);
    idle(6);

    for (int i = 0; i < 1000; i++)
      drive_d(9'($urandom), 8'($urandom), 8'($urandom),
              $urandom_range(0, 7) != 0, $urandom_range(0, 31) == 0);
    idle(10);

    for (int d = 0; d < 4; d++) begin
      check($sformatf("sum_drained[%0d]", d), 64'(sq[d].size()), 64'd0);
      check($sformatf("acc_drained[%0d]", d), 64'(aq[d].size()), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
